// File: rtl/fsic_phase_pkg.sv
// Shared types and sizing helpers for the coreclk/ioclk phase lock monitor.
package fsic_phase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam int MIN_CLK_RATIO = 2;

  function automatic int phase_width(input int ratio);
    return (ratio < MIN_CLK_RATIO) ? 1 : $clog2(ratio);
  endfunction

  // Counter that must hold values 0..thr inclusive.
  function automatic int cnt_width(input int thr);
    return (thr < 1) ? 1 : $clog2(thr + 1);
  endfunction

endpackage

// File: rtl/fsic_sat_cnt.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the count at one so that event is not lost.
module fsic_sat_cnt #(
  parameter int W = 8
) (
  input  logic         coreclk,
  input  logic         axis_rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge coreclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= inc_i ? W'(1) : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fsic_coreclk_phase_lock_mon.sv
// Coreclk-domain lock monitor: acquires a stable ioclk phase count, then
// tracks slips with hysteresis, a saturating error count and a sticky loss flag.
module fsic_coreclk_phase_lock_mon
  import fsic_phase_pkg::*;
#(
  parameter  int pCLK_RATIO  = 4,
  parameter  int pLOCK_CNT   = 8,
  parameter  int pUNLOCK_CNT = 4,
  parameter  int pERRCNT_W   = 8,
  localparam int PW          = phase_width(pCLK_RATIO)
) (
  input  logic                 coreclk,
  input  logic                 axis_rst_n,
  input  logic                 enable,
  input  logic [PW-1:0]        phase_in,
  input  logic                 clr_err,
  output logic                 locked,
  output logic [PW-1:0]        lock_phase,
  output logic                 lock_lost,
  output logic [pERRCNT_W-1:0] err_cnt,
  output logic [1:0]           state
);

  localparam int RUN_W  = cnt_width(pLOCK_CNT);
  localparam int MISS_W = cnt_width(pUNLOCK_CNT);

  if (pCLK_RATIO < MIN_CLK_RATIO) begin : g_bad_ratio
    $error("pCLK_RATIO must be >= 2");
  end
  if (pLOCK_CNT < 1) begin : g_bad_lock
    $error("pLOCK_CNT must be >= 1");
  end
  if (pUNLOCK_CNT < 1) begin : g_bad_unlock
    $error("pUNLOCK_CNT must be >= 1");
  end
  if (pERRCNT_W < 1) begin : g_bad_errw
    $error("pERRCNT_W must be >= 1");
  end

  state_e              state_q;
  logic [PW-1:0]       phase_q;
  logic [PW-1:0]       cand_q;
  logic [PW-1:0]       lock_phase_q;
  logic [RUN_W-1:0]    run_cnt_q;
  logic [RUN_W-1:0]    run_cnt_d;
  logic [MISS_W-1:0]   miss_cnt_q;
  logic [MISS_W-1:0]   miss_cnt_d;
  logic                locked_q;
  logic                lock_lost_q;
  logic                sample_valid;
  logic                count_err;
  logic                unlock_hit;
  logic                lock_hit;

  always_comb begin
    sample_valid = int'(phase_q) < pCLK_RATIO;
    // A new candidate restarts the run at one; a repeat extends it.
    if ((run_cnt_q != '0) && (phase_q == cand_q)) begin
      run_cnt_d = run_cnt_q + RUN_W'(1);
    end else begin
      run_cnt_d = RUN_W'(1);
    end
    lock_hit   = (state_q == ST_ACQUIRE) && sample_valid && (run_cnt_d == RUN_W'(pLOCK_CNT));
    count_err  = enable && (state_q == ST_LOCKED) && (!sample_valid || (phase_q != lock_phase_q));
    miss_cnt_d = miss_cnt_q + MISS_W'(1);
    unlock_hit = count_err && (miss_cnt_d == MISS_W'(pUNLOCK_CNT));
  end

  always_ff @(posedge coreclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      cand_q       <= '0;
      lock_phase_q <= '0;
      run_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      locked_q     <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      phase_q <= phase_in;
      if (!enable) begin
        state_q    <= ST_IDLE;
        locked_q   <= 1'b0;
        run_cnt_q  <= '0;
        miss_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q   <= ST_ACQUIRE;
            run_cnt_q <= '0;
          end
          ST_ACQUIRE: begin
            if (sample_valid) begin
              cand_q    <= phase_q;
              run_cnt_q <= run_cnt_d;
              if (lock_hit) begin
                state_q      <= ST_LOCKED;
                locked_q     <= 1'b1;
                lock_phase_q <= phase_q;
                miss_cnt_q   <= '0;
              end
            end else begin
              run_cnt_q <= '0;
            end
          end
          ST_LOCKED: begin
            if (unlock_hit) begin
              state_q    <= ST_ACQUIRE;
              locked_q   <= 1'b0;
              run_cnt_q  <= '0;
              miss_cnt_q <= '0;
            end else if (count_err) begin
              miss_cnt_q <= miss_cnt_d;
            end else begin
              miss_cnt_q <= '0;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
      if (unlock_hit) begin
        lock_lost_q <= 1'b1;
      end else if (clr_err) begin
        lock_lost_q <= 1'b0;
      end
    end
  end

  fsic_sat_cnt #(
    .W (pERRCNT_W)
  ) u_err_cnt (
    .coreclk    (coreclk),
    .axis_rst_n (axis_rst_n),
    .clr_i      (clr_err),
    .inc_i      (count_err),
    .cnt_o      (err_cnt)
  );

  assign locked     = locked_q;
  assign lock_phase = lock_phase_q;
  assign lock_lost  = lock_lost_q;
  assign state      = state_q;

endmodule

// File: tb/tb_fsic_coreclk_phase_lock_mon.sv
// Directed bench for the phase lock monitor across four parameter sets.
module tb_fsic_coreclk_phase_lock_mon;

  logic coreclk    = 1'b0;
  logic axis_rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 coreclk = ~coreclk;

  // a: ratio 4, lock 8, unlock 4, err width 8
  logic en_a = 1'b0, clr_a = 1'b0, locked_a, lost_a;
  logic [1:0] ph_a = 2'd0, lph_a, st_a;
  logic [7:0] err_a;
  // b: ratio 4, lock 8, unlock 32, err width 4
  logic en_b = 1'b0, clr_b = 1'b0, locked_b, lost_b;
  logic [1:0] ph_b = 2'd0, lph_b, st_b;
  logic [3:0] err_b;
  // c: ratio 3, lock 8, unlock 4, err width 8
  logic en_c = 1'b0, clr_c = 1'b0, locked_c, lost_c;
  logic [1:0] ph_c = 2'd0, lph_c, st_c;
  logic [7:0] err_c;
  // d: ratio 4, lock 1, unlock 1, err width 8
  logic en_d = 1'b0, clr_d = 1'b0, locked_d, lost_d;
  logic [1:0] ph_d = 2'd0, lph_d, st_d;
  logic [7:0] err_d;

  fsic_coreclk_phase_lock_mon #(.pCLK_RATIO(4), .pLOCK_CNT(8), .pUNLOCK_CNT(4), .pERRCNT_W(8)) dut_a (
    .coreclk(coreclk), .axis_rst_n(axis_rst_n), .enable(en_a), .phase_in(ph_a), .clr_err(clr_a),
    .locked(locked_a), .lock_phase(lph_a), .lock_lost(lost_a), .err_cnt(err_a), .state(st_a));
  fsic_coreclk_phase_lock_mon #(.pCLK_RATIO(4), .pLOCK_CNT(8), .pUNLOCK_CNT(32), .pERRCNT_W(4)) dut_b (
    .coreclk(coreclk), .axis_rst_n(axis_rst_n), .enable(en_b), .phase_in(ph_b), .clr_err(clr_b),
    .locked(locked_b), .lock_phase(lph_b), .lock_lost(lost_b), .err_cnt(err_b), .state(st_b));
  fsic_coreclk_phase_lock_mon #(.pCLK_RATIO(3), .pLOCK_CNT(8), .pUNLOCK_CNT(4), .pERRCNT_W(8)) dut_c (
    .coreclk(coreclk), .axis_rst_n(axis_rst_n), .enable(en_c), .phase_in(ph_c), .clr_err(clr_c),
    .locked(locked_c), .lock_phase(lph_c), .lock_lost(lost_c), .err_cnt(err_c), .state(st_c));
  fsic_coreclk_phase_lock_mon #(.pCLK_RATIO(4), .pLOCK_CNT(1), .pUNLOCK_CNT(1), .pERRCNT_W(8)) dut_d (
    .coreclk(coreclk), .axis_rst_n(axis_rst_n), .enable(en_d), .phase_in(ph_d), .clr_err(clr_d),
    .locked(locked_d), .lock_phase(lph_d), .lock_lost(lost_d), .err_cnt(err_d), .state(st_d));

  task automatic tick();
    @(posedge coreclk);
    #1;
  endtask

  task automatic test_reset();
    vectors++;
    if ({st_a, locked_a, lph_a, lost_a, err_a} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_a: got %h expected 0", {st_a, locked_a, lph_a, lost_a, err_a});
    end
    vectors++;
    if ({st_d, locked_d, lph_d, lost_d, err_d} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_d: got %h expected 0", {st_d, locked_d, lph_d, lost_d, err_d});
    end
    #10 axis_rst_n = 1'b1;
    tick();
    vectors++;
    if (st_a !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_idle: state got %0d expected 0", st_a);
    end
    $display("test_reset done");
  endtask

  task automatic test_lock_const();
    ph_a = 2'd2; tick();
    en_a = 1'b1; tick();
    vectors++;
    if (st_a !== 2'd1) begin
      miscompares++;
      $display("FAIL acquire_entry: state got %0d expected 1", st_a);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      vectors++;
      if (locked_a !== (k == 8)) begin
        miscompares++;
        $display("FAIL lock_timing cycle %0d: locked got %b expected %b", k, locked_a, (k == 8));
      end
    end
    vectors++;
    if ({st_a, lph_a, err_a} !== {2'd2, 2'd2, 8'd0}) begin
      miscompares++;
      $display("FAIL lock_const: got st=%0d ph=%0d err=%0d expected 2 2 0", st_a, lph_a, err_a);
    end
    $display("test_lock_const: state=%0d lock_phase=%0d", st_a, lph_a);
  endtask

  task automatic test_phase_change();
    en_a = 1'b0; tick();
    vectors++;
    if ({st_a, locked_a, lph_a} !== {2'd0, 1'b0, 2'd2}) begin
      miscompares++;
      $display("FAIL disable_idle: got st=%0d lk=%b ph=%0d expected 0 0 2", st_a, locked_a, lph_a);
    end
    en_a = 1'b1; tick();
    repeat (4) tick();
    ph_a = 2'd3;
    repeat (4) tick();
    vectors++;
    if (locked_a !== 1'b0) begin
      miscompares++;
      $display("FAIL change_no_lock_at_8: locked got %b expected 0", locked_a);
    end
    repeat (4) tick();
    vectors++;
    if (locked_a !== 1'b0) begin
      miscompares++;
      $display("FAIL change_no_lock_at_12: locked got %b expected 0", locked_a);
    end
    tick();
    vectors++;
    if ({st_a, locked_a, lph_a} !== {2'd2, 1'b1, 2'd3}) begin
      miscompares++;
      $display("FAIL change_relock: got st=%0d lk=%b ph=%0d expected 2 1 3", st_a, locked_a, lph_a);
    end
    $display("test_phase_change: lock_phase=%0d", lph_a);
  endtask

  task automatic test_slip_unlock();
    en_a = 1'b0; ph_a = 2'd2; tick();
    en_a = 1'b1; tick();
    repeat (8) tick();
    vectors++;
    if ({locked_a, lph_a, err_a} !== {1'b1, 2'd2, 8'd0}) begin
      miscompares++;
      $display("FAIL slip_lock: got lk=%b ph=%0d err=%0d expected 1 2 0", locked_a, lph_a, err_a);
    end
    ph_a = 2'd1; repeat (3) tick();
    ph_a = 2'd2; tick(); tick();
    vectors++;
    if ({st_a, locked_a, lost_a, err_a} !== {2'd2, 1'b1, 1'b0, 8'd3}) begin
      miscompares++;
      $display("FAIL slip_hold: got st=%0d lk=%b lost=%b err=%0d expected 2 1 0 3", st_a, locked_a, lost_a, err_a);
    end
    ph_a = 2'd1; repeat (4) tick();
    vectors++;
    if ({locked_a, err_a} !== {1'b1, 8'd6}) begin
      miscompares++;
      $display("FAIL slip_three_miss: got lk=%b err=%0d expected 1 6", locked_a, err_a);
    end
    tick();
    vectors++;
    if ({st_a, locked_a, lost_a, err_a} !== {2'd1, 1'b0, 1'b1, 8'd7}) begin
      miscompares++;
      $display("FAIL slip_unlock: got st=%0d lk=%b lost=%b err=%0d expected 1 0 1 7", st_a, locked_a, lost_a, err_a);
    end
    $display("test_slip_unlock: err_cnt=%0d lock_lost=%b", err_a, lost_a);
  endtask

  task automatic test_clr_err();
    repeat (8) tick();
    vectors++;
    if ({locked_a, lph_a} !== {1'b1, 2'd1}) begin
      miscompares++;
      $display("FAIL reacquire: got lk=%b ph=%0d expected 1 1", locked_a, lph_a);
    end
    ph_a = 2'd3; clr_a = 1'b1; tick();
    vectors++;
    if ({locked_a, lost_a, err_a} !== {1'b1, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL clr_plain: got lk=%b lost=%b err=%0d expected 1 0 0", locked_a, lost_a, err_a);
    end
    clr_a = 1'b0; repeat (3) tick();
    vectors++;
    if (err_a !== 8'd3) begin
      miscompares++;
      $display("FAIL clr_recount: err got %0d expected 3", err_a);
    end
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    vectors++;
    if ({st_a, locked_a, lost_a, err_a} !== {2'd1, 1'b0, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL clr_vs_unlock: got st=%0d lk=%b lost=%b err=%0d expected 1 0 1 1", st_a, locked_a, lost_a, err_a);
    end
    $display("test_clr_err: err_cnt=%0d lock_lost=%b", err_a, lost_a);
  endtask

  task automatic test_enable_drop();
    repeat (8) tick();
    vectors++;
    if ({locked_a, lph_a} !== {1'b1, 2'd3}) begin
      miscompares++;
      $display("FAIL drop_prelock: got lk=%b ph=%0d expected 1 3", locked_a, lph_a);
    end
    ph_a = 2'd0; tick();
    en_a = 1'b0; tick();
    vectors++;
    if ({st_a, locked_a, lph_a, lost_a, err_a} !== {2'd0, 1'b0, 2'd3, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL drop_hold: got st=%0d lk=%b ph=%0d lost=%b err=%0d expected 0 0 3 1 1", st_a, locked_a, lph_a, lost_a, err_a);
    end
    $display("test_enable_drop: state=%0d lock_phase=%0d err_cnt=%0d", st_a, lph_a, err_a);
  endtask

  task automatic test_saturate();
    ph_b = 2'd2; tick();
    en_b = 1'b1; tick();
    repeat (8) tick();
    vectors++;
    if ({locked_b, lph_b} !== {1'b1, 2'd2}) begin
      miscompares++;
      $display("FAIL sat_lock: got lk=%b ph=%0d expected 1 2", locked_b, lph_b);
    end
    ph_b = 2'd1; repeat (16) tick();
    vectors++;
    if (err_b !== 4'd15) begin
      miscompares++;
      $display("FAIL sat_reach: err got %0d expected 15", err_b);
    end
    repeat (5) tick();
    vectors++;
    if ({st_b, locked_b, err_b} !== {2'd2, 1'b1, 4'd15}) begin
      miscompares++;
      $display("FAIL sat_hold: got st=%0d lk=%b err=%0d expected 2 1 15", st_b, locked_b, err_b);
    end
    clr_b = 1'b1; tick(); clr_b = 1'b0;
    vectors++;
    if ({locked_b, err_b} !== {1'b1, 4'd1}) begin
      miscompares++;
      $display("FAIL sat_clr_inc: got lk=%b err=%0d expected 1 1", locked_b, err_b);
    end
    $display("test_saturate: err_cnt=%0d", err_b);
  endtask

  task automatic test_invalid_phase();
    ph_c = 2'd3; tick();
    en_c = 1'b1; tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      vectors++;
      if ({st_c, locked_c, dut_c.run_cnt_q} !== {2'd1, 1'b0, 4'd0}) begin
        miscompares++;
        $display("FAIL invalid_hold cycle %0d: got st=%0d lk=%b run=%0d expected 1 0 0", k, st_c, locked_c, dut_c.run_cnt_q);
      end
    end
    ph_c = 2'd2; tick();
    repeat (7) tick();
    vectors++;
    if (locked_c !== 1'b0) begin
      miscompares++;
      $display("FAIL ratio3_early: locked got %b expected 0", locked_c);
    end
    tick();
    vectors++;
    if ({locked_c, lph_c} !== {1'b1, 2'd2}) begin
      miscompares++;
      $display("FAIL ratio3_lock: got lk=%b ph=%0d expected 1 2", locked_c, lph_c);
    end
    ph_c = 2'd3; tick(); tick();
    vectors++;
    if ({locked_c, err_c} !== {1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL ratio3_invalid_err: got lk=%b err=%0d expected 1 1", locked_c, err_c);
    end
    $display("test_invalid_phase: err_cnt=%0d", err_c);
  endtask

  task automatic test_min_thresholds();
    ph_d = 2'd1; tick();
    en_d = 1'b1; tick();
    vectors++;
    if (st_d !== 2'd1) begin
      miscompares++;
      $display("FAIL min_acquire: state got %0d expected 1", st_d);
    end
    tick();
    vectors++;
    if ({st_d, locked_d, lph_d} !== {2'd2, 1'b1, 2'd1}) begin
      miscompares++;
      $display("FAIL min_lock: got st=%0d lk=%b ph=%0d expected 2 1 1", st_d, locked_d, lph_d);
    end
    ph_d = 2'd2; tick(); tick();
    vectors++;
    if ({st_d, locked_d, lost_d, err_d} !== {2'd1, 1'b0, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL min_unlock: got st=%0d lk=%b lost=%b err=%0d expected 1 0 1 1", st_d, locked_d, lost_d, err_d);
    end
    tick();
    vectors++;
    if ({locked_d, lph_d} !== {1'b1, 2'd2}) begin
      miscompares++;
      $display("FAIL min_relock: got lk=%b ph=%0d expected 1 2", locked_d, lph_d);
    end
    $display("test_min_thresholds: lock_phase=%0d", lph_d);
  endtask

  task automatic test_async_reset();
    @(posedge coreclk);
    #3 axis_rst_n = 1'b0;
    #1;
    vectors++;
    if ({st_b, locked_b, lph_b, lost_b, err_b} !== 10'd0) begin
      miscompares++;
      $display("FAIL async_reset_b: got %h expected 0", {st_b, locked_b, lph_b, lost_b, err_b});
    end
    vectors++;
    if ({st_a, locked_a, lph_a, lost_a, err_a} !== 14'd0) begin
      miscompares++;
      $display("FAIL async_reset_a: got %h expected 0", {st_a, locked_a, lph_a, lost_a, err_a});
    end
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
    #3 axis_rst_n = 1'b1;
    tick(); tick();
    vectors++;
    if ({st_a, st_b} !== 4'd0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got st_a=%0d st_b=%0d expected 0 0", st_a, st_b);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    #2;
    test_reset();
    test_lock_const();
    test_phase_change();
    test_slip_unlock();
    test_clr_err();
    test_enable_drop();
    test_saturate();
    test_invalid_phase();
    test_min_thresholds();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fsic_coreclk_phase_lock_mon.md
Name: fsic_coreclk_phase_lock_mon

Overview:
- Coreclk-domain lock monitor for the io_serdes coreclk/ioclk phase relationship.
- Consumes the per-cycle ioclk phase count sampled at each coreclk edge. Declares lock once a stable phase is held for a programmable number of cycles, then tracks slips, counts errors and reports loss of lock.
- Generalises the fixed ratio-4 phase detection to any clock ratio, with hysteresis and status reporting.

Parameters:
- pCLK_RATIO, 4: ioclk/coreclk ratio, >=2. PW = $clog2(pCLK_RATIO).
- pLOCK_CNT, 8: consecutive identical valid samples required to lock, >=1.
- pUNLOCK_CNT, 4: consecutive mismatching samples that drop lock, >=1.
- pERRCNT_W, 8: width of the saturating error counter, >=1.

Ports:
- coreclk  in  1  core clock.
- axis_rst_n  in  1  reset.
- enable  in  1  monitor enable.
- phase_in  in  PW  ioclk phase count sampled in the coreclk domain.
- clr_err  in  1  single-cycle clear of err_cnt and lock_lost.
- locked  out  1  lock status.
- lock_phase  out  PW  phase value captured at lock.
- lock_lost  out  1  sticky flag: a lock was lost.
- err_cnt  out  pERRCNT_W  saturating count of mismatches while LOCKED.
- state  out  2  FSM state: IDLE=0, ACQUIRE=1, LOCKED=2.

Behaviour:
- Reset and clock: reset axis_rst_n, asynchronous, active-low; clock coreclk.
- Reset values: all outputs 0, state IDLE. Internal phase_q, cand, run_cnt and miss_cnt are also 0.
- Input stage: phase_in is registered once into phase_q. All decisions use phase_q.
- Validity: a sample is valid iff phase_q < pCLK_RATIO. This only matters when pCLK_RATIO is not a power of 2.
- IDLE:
  - locked=0.
  - enable=1 -> ACQUIRE on the next edge, with run_cnt=0.
- ACQUIRE, evaluated on each edge:
  - valid and run_cnt!=0 and phase_q==cand: run_cnt+1.
  - Other valid sample: cand<=phase_q, run_cnt<=1.
  - Invalid sample: run_cnt<=0.
  - When a valid sample makes the count reach pLOCK_CNT: state<=LOCKED, locked<=1, lock_phase<=cand (phase_q when pLOCK_CNT=1), miss_cnt<=0.
  - With phase_q stable on entry, locked is high exactly pLOCK_CNT cycles after state first reads ACQUIRE.
- LOCKED, evaluated on each edge:
  - Mismatch means an invalid sample or phase_q != lock_phase.
  - On mismatch: err_cnt+1, saturating at 2^pERRCNT_W-1; miss_cnt+1.
  - On a match: miss_cnt<=0.
  - When miss_cnt reaches pUNLOCK_CNT: state<=ACQUIRE, locked<=0, lock_lost<=1, run_cnt<=0.
  - The sample that triggers unlock does not seed cand.
  - lock_phase holds its last value.
- enable=0 in any state:
  - Next edge: state IDLE, locked=0, run_cnt=miss_cnt=0.
  - err_cnt, lock_lost and lock_phase hold.
  - No mismatch is counted in that cycle.
- clr_err:
  - Next edge: err_cnt<=0 and lock_lost<=0.
  - If a mismatch is counted in the same cycle, err_cnt<=1.
  - If an unlock occurs in the same cycle, lock_lost<=1 (set wins).
  - No effect on the FSM.
- Boundaries:
  - pLOCK_CNT=1: the first valid sample in ACQUIRE locks.
  - pUNLOCK_CNT=1: a single mismatch unlocks.
  - run_cnt and miss_cnt never exceed their thresholds; widths are $clog2(threshold+1).
- Asynchronous reset mid-operation: immediate return to reset values.
- Elaboration: parameter violations must cause an elaboration error.

Decomposition:
- Package fsic_phase_pkg:
  - 2-bit state encodings IDLE/ACQUIRE/LOCKED.
  - localparam helper for PW.
  - Counter-width function.
- One sub-module fsic_sat_cnt (parameter W): synchronous clear, increment, saturation and clear-vs-increment priority. Used for err_cnt.
- The FSM stays in the top module.

Test Plan:
1. Reset asserted mid-LOCKED -> all outputs 0 and state=0 immediately. After release with enable=0, stays IDLE.
2. pCLK_RATIO=4, pLOCK_CNT=8; enable=1 with phase_in=2 constant -> locked=1 and lock_phase=2 exactly 8 cycles after state=1; err_cnt=0.
3. ACQUIRE with phase_in=2 for 5 cycles, then 3 constant -> no lock at 8; locked with lock_phase=3 after 8 samples of 3.
4. LOCKED at 2, pUNLOCK_CNT=4:
   - 3 cycles of phase 1, then phase 2 -> stays locked, err_cnt=3.
   - Then 4 cycles of phase 1 -> state=1, locked=0, lock_lost=1, err_cnt=7.
5. pERRCNT_W=4, pUNLOCK_CNT=32; 20 mismatches while locked -> err_cnt saturates at 15. Then clr_err with a coincident mismatch -> err_cnt=1.
6. pCLK_RATIO=3, phase_in=3 held 20 cycles -> never locks, run_cnt stays 0. Separately, clr_err coincident with a lock-loss edge -> lock_lost=1. Dropping enable while LOCKED -> state=0, lock_phase and err_cnt retained.
